sync_dncnt: RTL and testbench
=============================

Name: sync_dncnt

Overview:
- Loadable synchronous down-counter / interval timer. It is the counting-down companion to the team's small synchronous up-counters.
- Counts a programmed reload value down to zero on enabled cycles.
- Flags terminal count with a one-cycle pulse.
- Runs either once (one-shot) or periodically (auto-reload).
- Used as a tick/timeout generator next to the flop-built counters.

Parameters:
- WIDTH, 4, counter and reload-value width in bits (legal range 2..16).

Ports:
- clk  input  1  clock; all state updates on the falling edge.
- rst  input  1  synchronous reset, active-low; sampled on the falling edge of clk.
- en  input  1  count enable; decrement/reload only when 1.
- load  input  1  load reload register and counter from load_val.
- load_val  input  WIDTH  value captured on load.
- start  input  1  start a count sequence.
- mode  input  1  0 = one-shot, 1 = auto-reload.
- cnt  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered, 1 cycle.
- busy  output  1  1 while in RUN.
- done  output  1  1 while in DONE (one-shot finished).

Behaviour:
- **Timing:** all outputs registered; every update on the falling clk edge.
- **Reset (rst=0 at an edge):** overrides everything.
  - cnt=0, reload_reg=0, tc=0, busy=0, done=0, state=IDLE.
  - Reset asserted mid-RUN aborts at that edge with no tc.
- **Priority:** reset > load > start > count.
- **FSM states:** IDLE, RUN, DONE.
  - busy=1 only in RUN.
  - done=1 only in DONE.
- **load=1 (any state):**
  - reload_reg<=load_val, cnt<=load_val, state<=IDLE, tc<=0.
  - A load during RUN aborts the sequence; a simultaneous start is ignored.
- **start=1 in IDLE or DONE (no load):**
  - reload_reg!=0: cnt<=reload_reg, state<=RUN.
  - reload_reg==0: cnt<=0, tc<=1 for one cycle, state<=DONE, regardless of mode.
  - start does not need en.
- **start in RUN:** ignored; no restart.
- **RUN with en=0:** cnt, state and tc hold; tc is 0.
- **RUN with en=1:**
  - cnt>1: cnt<=cnt-1.
  - cnt==1: cnt<=0, tc<=1 on that same edge, so tc and cnt==0 are visible together for one cycle.
    - If mode==0, state<=DONE.
    - If mode==1, stay in RUN.
  - cnt==0 (only reachable with mode==1): cnt<=reload_reg; this is the reload cycle, not a decrement.
  - Resulting auto-reload period = reload_reg+1 enabled cycles; tc fires once per period.
- **tc pulse rule:**
  - tc is 1 for exactly one cycle after each terminal edge and 0 otherwise.
  - tc is never held, even if en stays 1 in DONE.
- **mode:** sampled at the cnt==1 edge. Changing mode mid-count takes effect at the next terminal.
- **Width/arithmetic:**
  - Unsigned WIDTH-bit count.
  - No underflow: the counter never decrements from 0.
  - load_val = all-ones is legal (maximum period).
- **DONE:** holds cnt=0, done=1 until start or load.

Optional Feature:
- Macro: SYNC_DNCNT_GRAY_EN.
- Defined:
  - Adds output port cnt_gray, width WIDTH.
  - cnt_gray = registered binary-to-Gray of the next cnt, updated on the same edge as cnt, so cnt_gray == cnt ^ (cnt>>1) in every cycle.
  - Reset value 0.
- Not defined: port absent; no extra logic; all other behaviour identical.

Test Plan:
- **Reset:**
  - Stimulus: hold rst=0 for 2 edges with load=1, start=1, en=1.
  - Required: cnt=0, tc=0, busy=0, done=0 after each edge; after rst=1, outputs unchanged until stimulus.
- **One-shot (WIDTH=4):**
  - Stimulus: load_val=5, load; mode=0; start; en=1.
  - Required: cnt 5,4,3,2,1,0; tc=1 only in the cycle cnt==0; done=1 and busy=0 from that cycle; cnt stays 0 for 4 more enabled cycles with tc=0.
- **Auto-reload:**
  - Stimulus: load_val=3, mode=1, start, en=1 for 10 edges.
  - Required: cnt 3,2,1,0,3,2,1,0,3,2; tc=1 exactly in the two cnt==0 cycles; busy=1 throughout.
- **Enable gaps and mid-run load:**
  - Stimulus: one-shot 4, en toggles 1,0,0,1.
  - Required: cnt 4,3,3,3,2.
  - Then load=1 with load_val=9 and start=1 simultaneously: cnt=9, state IDLE, busy=0, no tc.
- **Zero reload and reset mid-run:**
  - Stimulus: load 0 then start.
  - Required: tc=1 for one cycle, done=1, cnt=0.
  - Then load 7, start, 2 enabled edges, rst=0 at cnt=5: next edge cnt=0, busy=0, tc never asserted.
- **Gray (SYNC_DNCNT_GRAY_EN defined, WIDTH=4):**
  - Stimulus: load_val=15, one-shot.
  - Required: cnt_gray follows 1000,1001,1011,1010,… and equals cnt^(cnt>>1) every cycle, including 0 at reset and DONE.

Source files
------------

// File: rtl/sync_dncnt.sv
// Loadable down-counter / interval timer with one-shot and auto-reload modes.
// Optional registered Gray-coded count output enabled by SYNC_DNCNT_GRAY_EN.
module sync_dncnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             mode,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             busy,
  output logic             done
`ifdef SYNC_DNCNT_GRAY_EN
  ,
  output logic [WIDTH-1:0] cnt_gray
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (load) begin
      reload_d = load_val;
      cnt_d    = load_val;
      state_d  = IDLE;
    end else if (start && state_q != RUN) begin
      if (reload_q == '0) begin
        cnt_d   = '0;
        tc_d    = 1'b1;
        state_d = DONE;
      end else begin
        cnt_d   = reload_q;
        state_d = RUN;
      end
    end else if (state_q == RUN && en) begin
      if (cnt_q == '0) begin
        // Auto-reload cycle: the period is reload+1 enabled cycles.
        cnt_d = reload_q;
      end else if (cnt_q == WIDTH'(1)) begin
        cnt_d = '0;
        tc_d  = 1'b1;
        if (!mode) state_d = DONE;
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
      end
    end
  end

  // All state updates happen on the falling edge of clk.
  always_ff @(negedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign cnt  = cnt_q;
  assign tc   = tc_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

`ifdef SYNC_DNCNT_GRAY_EN
  logic [WIDTH-1:0] gray_q, gray_d;

  assign gray_d = cnt_d ^ (cnt_d >> 1);

  always_ff @(negedge clk) begin
    if (!rst) gray_q <= '0;
    else      gray_q <= gray_d;
  end

  assign cnt_gray = gray_q;
`endif

endmodule

// File: tb/tb_sync_dncnt.sv
// Self-checking bench for sync_dncnt: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural timer model.
module tb_sync_dncnt;

  localparam int WIDTH = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             clk;
  logic             rst;
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             busy;
  logic             done;
`ifdef SYNC_DNCNT_GRAY_EN
  logic [WIDTH-1:0] cnt_gray;
`endif

  int checks = 0;
  int errors = 0;

  sync_dncnt #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .mode     (mode),
    .cnt      (cnt),
    .tc       (tc),
    .busy     (busy),
    .done     (done)
`ifdef SYNC_DNCNT_GRAY_EN
    ,
    .cnt_gray (cnt_gray)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a timer that is either idle, running or finished,
  // with an integer count that is reloaded, stepped down or wrapped.
  int m_cnt      = 0;
  int m_reload   = 0;
  bit m_tc       = 0;
  bit m_running  = 0;
  bit m_finished = 0;
  bit m_valid    = 0;

  always @(negedge clk) begin
    if (!rst) begin
      m_cnt = 0; m_reload = 0; m_tc = 0;
      m_running = 0; m_finished = 0; m_valid = 1;
    end else begin
      m_tc = 0;
      if (load) begin
        m_reload = int'(load_val);
        m_cnt = m_reload;
        m_running = 0; m_finished = 0;
      end else if (start && !m_running) begin
        if (m_reload == 0) begin
          m_cnt = 0; m_tc = 1; m_finished = 1;
        end else begin
          m_cnt = m_reload; m_running = 1; m_finished = 0;
        end
      end else if (m_running && en) begin
        if (m_cnt == 0) m_cnt = m_reload;
        else begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) begin
            m_tc = 1;
            if (!mode) begin m_running = 0; m_finished = 1; end
          end
        end
      end
    end
  end

  // Compare on the rising edge, away from the falling update edge.
  always @(posedge clk) begin
    if (m_valid) begin
      check("cnt",  int'(cnt),  m_cnt);
      check("tc",   int'(tc),   int'(m_tc));
      check("busy", int'(busy), int'(m_running));
      check("done", int'(done), int'(m_finished));
`ifdef SYNC_DNCNT_GRAY_EN
      check("cnt_gray", int'(cnt_gray), m_cnt ^ (m_cnt >> 1));
`endif
    end
  end

  // One full clock: through the update edge, then just past the compare edge.
  task automatic cyc();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load = 1'b0; start = 1'b0; en = 1'b0;
  endtask

  int exp_ar[9] = '{2, 1, 0, 3, 2, 1, 0, 3, 2};
  int exp_en[4] = '{3, 3, 3, 2};
  bit en_seq[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    rst = 1'b0; load = 1'b1; start = 1'b1; en = 1'b1; mode = 1'b0; load_val = 4'd5;

    // Reset dominates load/start/en.
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("rst_cnt", int'(cnt), 0);
      check("rst_tc", int'(tc), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
    end
    rst = 1'b1; idle_inputs();
    cyc();
    check("post_rst_cnt", int'(cnt), 0);

    // One-shot of 5.
    load = 1'b1; load_val = 4'd5; cyc();
    load = 1'b0; check("os_load", int'(cnt), 5);
    mode = 1'b0; start = 1'b1; en = 1'b1; cyc();
    start = 1'b0;
    check("os_start", int'(cnt), 5);
    check("os_busy", int'(busy), 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("os_cnt", int'(cnt), 4 - i);
      check("os_tc", int'(tc), (i == 4) ? 1 : 0);
    end
    check("os_done", int'(done), 1);
    check("os_idle", int'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("os_hold_cnt", int'(cnt), 0);
      check("os_hold_tc", int'(tc), 0);
    end

    // Auto-reload of 3: period 4.
    en = 1'b0; load = 1'b1; load_val = 4'd3; cyc();
    load = 1'b0; mode = 1'b1; start = 1'b1; en = 1'b1; cyc();
    start = 1'b0;
    check("ar_start", int'(cnt), 3);
    for (int i = 0; i < 9; i++) begin
      cyc();
      check("ar_cnt", int'(cnt), exp_ar[i]);
      check("ar_tc", int'(tc), (exp_ar[i] == 0) ? 1 : 0);
      check("ar_busy", int'(busy), 1);
    end

    // Enable gaps, then load overriding start mid-run.
    mode = 1'b0; en = 1'b0; load = 1'b1; load_val = 4'd4; cyc();
    load = 1'b0; start = 1'b1; cyc();
    start = 1'b0;
    check("gap_start", int'(cnt), 4);
    for (int i = 0; i < 4; i++) begin
      en = en_seq[i]; cyc();
      check("gap_cnt", int'(cnt), exp_en[i]);
    end
    load = 1'b1; start = 1'b1; load_val = 4'd9; cyc();
    idle_inputs();
    check("ld_cnt", int'(cnt), 9);
    check("ld_busy", int'(busy), 0);
    check("ld_tc", int'(tc), 0);

    // Zero reload finishes immediately with a tc pulse.
    load = 1'b1; load_val = 4'd0; cyc();
    load = 1'b0; start = 1'b1; cyc();
    start = 1'b0;
    check("z_tc", int'(tc), 1);
    check("z_done", int'(done), 1);
    check("z_cnt", int'(cnt), 0);
    cyc();
    check("z_tc_clr", int'(tc), 0);

    // Reset mid-run aborts without tc.
    load = 1'b1; load_val = 4'd7; cyc();
    load = 1'b0; start = 1'b1; en = 1'b1; cyc();
    start = 1'b0;
    cyc(); cyc();
    check("mr_cnt5", int'(cnt), 5);
    rst = 1'b0; cyc();
    rst = 1'b1;
    check("mr_cnt", int'(cnt), 0);
    check("mr_busy", int'(busy), 0);
    check("mr_tc", int'(tc), 0);

`ifdef SYNC_DNCNT_GRAY_EN
    en = 1'b0; load = 1'b1; load_val = 4'd15; cyc();
    load = 1'b0; check("g_15", int'(cnt_gray), 8);
    mode = 1'b0; start = 1'b1; en = 1'b1; cyc();
    start = 1'b0;
    cyc(); check("g_14", int'(cnt_gray), 9);
    cyc(); check("g_13", int'(cnt_gray), 11);
    cyc(); check("g_12", int'(cnt_gray), 10);
    repeat (14) cyc();
    check("g_done", int'(cnt_gray), 0);
`endif

    // Randomized traffic, checked every cycle by the compare process.
    idle_inputs();
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(99) != 0);
      load  = ($urandom_range(19) == 0);
      start = ($urandom_range(7) == 0);
      en    = ($urandom_range(9) < 7);
      if ($urandom_range(15) == 0) mode = ~mode;
      case ($urandom_range(3))
        0:       load_val = '0;
        1:       load_val = WIDTH'(MAXV);
        default: load_val = WIDTH'($urandom_range(MAXV));
      endcase
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
